// File: rtl/match_ctl_if.sv
// Event and status bundle between the match controller and the ball/score logic.
interface match_ctl_if #(
  parameter int unsigned SCORE_W = 4
) ();
  logic               frame_tick;
  logic               goal_p1;
  logic               goal_p2;
  logic               start_btn;
  logic               pause_btn;
  logic               ball_enable;
  logic               ball_reset;
  logic               serve_side;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [1:0]         winner;
  logic [2:0]         state_out;
  logic               disp_blink;

  modport master (
    input  frame_tick, goal_p1, goal_p2, start_btn, pause_btn,
    output ball_enable, ball_reset, serve_side, score_p1, score_p2, winner, state_out,
           disp_blink
  );

  modport slave (
    output frame_tick, goal_p1, goal_p2, start_btn, pause_btn,
    input  ball_enable, ball_reset, serve_side, score_p1, score_p2, winner, state_out,
           disp_blink
  );
endinterface

// File: rtl/match_ctl.sv
// Air hockey match controller: frame-timed serve/goal pauses, pause toggle, saturating scores,
// configurable win rule and a blinking match-over display.
module match_ctl #(
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned WIN_BY_TWO   = 0,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned GOAL_FRAMES  = 90,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk_in,
  input  logic        rst,
  match_ctl_if.master bus
);

  localparam int unsigned MaxSg     = (SERVE_FRAMES > GOAL_FRAMES) ? SERVE_FRAMES : GOAL_FRAMES;
  localparam int unsigned MaxFrames = (MaxSg > BLINK_FRAMES) ? MaxSg : BLINK_FRAMES;
  localparam int unsigned CntW      = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;

  localparam logic [CntW-1:0]       ServeLast = CntW'(SERVE_FRAMES - 1);
  localparam logic [CntW-1:0]       GoalLast  = CntW'(GOAL_FRAMES - 1);
  localparam logic [CntW-1:0]       BlinkLast = CntW'(BLINK_FRAMES - 1);
  localparam logic [SCORE_W-1:0]    ScoreMax  = '1;
  localparam logic [SCORE_W-1:0]    WinScore  = SCORE_W'(WIN_SCORE);
  localparam logic signed [SCORE_W:0] Two     = (SCORE_W + 1)'(2);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StServe  = 3'd1,
    StPlay   = 3'd2,
    StGoal   = 3'd3,
    StPaused = 3'd4,
    StOver   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0]         winner_q, winner_d;
  logic               side_q, side_d;
  logic               blink_q, blink_d;
  logic               ben_q, ben_d;
  logic               brst_q, brst_d;
  logic               start_q, pause_q;

  logic                 start_edge, pause_edge;
  logic signed [SCORE_W:0] diff12, diff21;
  logic                 win_p1, win_p2;

  assign start_edge = bus.start_btn & ~start_q;
  assign pause_edge = bus.pause_btn & ~pause_q;

  // Extra sign bit so a trailing player's difference stays negative.
  assign diff12 = $signed({1'b0, s1_q}) - $signed({1'b0, s2_q});
  assign diff21 = $signed({1'b0, s2_q}) - $signed({1'b0, s1_q});

  assign win_p1 = (s1_q >= WinScore) &&
                  ((WIN_BY_TWO == 0) || (diff12 >= Two) || ((s1_q == ScoreMax) && (s1_q > s2_q)));
  assign win_p2 = (s2_q >= WinScore) &&
                  ((WIN_BY_TWO == 0) || (diff21 >= Two) || ((s2_q == ScoreMax) && (s2_q > s1_q)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    winner_d = winner_q;
    side_d   = side_q;
    blink_d  = blink_q;
    brst_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          s1_d     = '0;
          s2_d     = '0;
          winner_d = 2'b00;
          brst_d   = 1'b1;
          cnt_d    = '0;
          state_d  = StServe;
        end
      end
      StServe: begin
        if (bus.frame_tick) begin
          if (cnt_q == ServeLast) begin
            cnt_d   = '0;
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPlay: begin
        // A goal always takes priority over a simultaneous pause edge.
        if (bus.goal_p1 || bus.goal_p2) begin
          cnt_d   = '0;
          state_d = StGoal;
          if (bus.goal_p1 && !bus.goal_p2) begin
            s1_d   = (s1_q == ScoreMax) ? s1_q : s1_q + SCORE_W'(1);
            side_d = 1'b1;
          end else if (bus.goal_p2 && !bus.goal_p1) begin
            s2_d   = (s2_q == ScoreMax) ? s2_q : s2_q + SCORE_W'(1);
            side_d = 1'b0;
          end
        end else if (pause_edge) begin
          state_d = StPaused;
        end
      end
      StPaused: begin
        if (pause_edge) begin
          state_d = StPlay;
        end
      end
      StGoal: begin
        if (win_p1 || win_p2) begin
          winner_d = win_p1 ? 2'b01 : 2'b10;
          blink_d  = 1'b0;
          cnt_d    = '0;
          state_d  = StOver;
        end else if (bus.frame_tick) begin
          if (cnt_q == GoalLast) begin
            cnt_d   = '0;
            brst_d  = 1'b1;
            state_d = StServe;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StOver: begin
        if (start_edge) begin
          s1_d     = '0;
          s2_d     = '0;
          winner_d = 2'b00;
          blink_d  = 1'b0;
          cnt_d    = '0;
          state_d  = StIdle;
        end else if (bus.frame_tick) begin
          if (cnt_q == BlinkLast) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    ben_d = (state_d == StPlay);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      winner_q <= 2'b00;
      side_q   <= 1'b0;
      blink_q  <= 1'b0;
      ben_q    <= 1'b0;
      brst_q   <= 1'b0;
      // Held buttons must not register as an edge once reset lifts.
      start_q  <= bus.start_btn;
      pause_q  <= bus.pause_btn;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      winner_q <= winner_d;
      side_q   <= side_d;
      blink_q  <= blink_d;
      ben_q    <= ben_d;
      brst_q   <= brst_d;
      start_q  <= bus.start_btn;
      pause_q  <= bus.pause_btn;
    end
  end

  assign bus.ball_enable = ben_q;
  assign bus.ball_reset  = brst_q;
  assign bus.serve_side  = side_q;
  assign bus.score_p1    = s1_q;
  assign bus.score_p2    = s2_q;
  assign bus.winner      = winner_q;
  assign bus.state_out   = state_q;
  assign bus.disp_blink  = blink_q;

endmodule
